// File: rtl/modulus_carry_normalizer.sv
// Normalizes a vector of redundant column sums by repeated carry-propagation passes.
// Optional pass statistics ports are built when MODULUS_NORMALIZER_PASS_STATS_EN is defined.
module modulus_carry_normalizer #(
  parameter int unsigned NUM_WORDS  = 8,
  parameter int unsigned BIT_LEN    = 58,
  parameter int unsigned WORD_LEN   = 51,
  parameter int unsigned MAX_PASSES = 4,
  parameter int unsigned OVF_LEN    = 16
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [NUM_WORDS-1:0][BIT_LEN-1:0]    in_sums,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [NUM_WORDS-1:0][WORD_LEN-1:0]   out_words,
  output logic [OVF_LEN-1:0]                   out_ovf,
  output logic                                 out_clean
`ifdef MODULUS_NORMALIZER_PASS_STATS_EN
  ,
  output logic [$clog2(MAX_PASSES+1)-1:0]      out_passes,
  output logic [15:0]                          stat_limit_hits
`endif
);

  localparam int unsigned CAR_W = BIT_LEN - WORD_LEN;
  localparam int unsigned CNT_W = $clog2(MAX_PASSES + 1);

  typedef enum logic [1:0] {IDLE, PASS, DONE} state_t;

  state_t                            state;
  state_t                            state_nxt;
  logic [NUM_WORDS-1:0][BIT_LEN-1:0] w;
  logic [NUM_WORDS-1:0][BIT_LEN-1:0] w_nxt;
  logic [NUM_WORDS-1:0][CAR_W-1:0]   car;
  logic                              any_car;
  logic                              post_clean;
  logic                              last_pass;
  logic [CNT_W-1:0]                  pass_cnt;
  logic [OVF_LEN-1:0]                ovf;
  logic                              clean;
  logic                              in_ready_nxt;
  logic                              out_valid_nxt;

  // Carry extraction from the current words and the result of one pass over them
  always_comb begin
    any_car    = 1'b0;
    post_clean = 1'b1;
    for (int unsigned i = 0; i < NUM_WORDS; i++) begin
      car[i]  = w[i][BIT_LEN-1:WORD_LEN];
      any_car = any_car | (car[i] != '0);
    end
    w_nxt[0] = BIT_LEN'(w[0][WORD_LEN-1:0]);
    for (int unsigned i = 1; i < NUM_WORDS; i++) begin
      w_nxt[i] = BIT_LEN'(w[i][WORD_LEN-1:0]) + BIT_LEN'(car[i-1]);
    end
    for (int unsigned i = 0; i < NUM_WORDS; i++) begin
      post_clean = post_clean & (w_nxt[i][BIT_LEN-1:WORD_LEN] == '0);
    end
  end

  assign last_pass = (pass_cnt + CNT_W'(1)) == CNT_W'(MAX_PASSES);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = PASS;
      PASS:    if (!any_car || last_pass) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs decoded from the next state so they leave a flop
  always_comb begin
    in_ready_nxt  = 1'b0;
    out_valid_nxt = 1'b0;
    case (state_nxt)
      IDLE:    in_ready_nxt  = 1'b1;
      DONE:    out_valid_nxt = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      in_ready  <= in_ready_nxt;
      out_valid <= out_valid_nxt;
    end
  end

  // Word registers, carry accumulator, pass counter and clean flag
  always_ff @(posedge clk) begin
    if (reset) begin
      w        <= '0;
      ovf      <= '0;
      pass_cnt <= '0;
      clean    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            w        <= in_sums;
            ovf      <= '0;
            pass_cnt <= '0;
          end
        end
        PASS: begin
          if (!any_car) begin
            clean <= 1'b1;
          end else begin
            w        <= w_nxt;
            ovf      <= ovf + OVF_LEN'(car[NUM_WORDS-1]);
            pass_cnt <= pass_cnt + CNT_W'(1);
            if (last_pass) clean <= post_clean;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_WORDS; i++) begin
      out_words[i] = w[i][WORD_LEN-1:0];
    end
  end

  assign out_ovf   = ovf;
  assign out_clean = clean;

`ifdef MODULUS_NORMALIZER_PASS_STATS_EN
  assign out_passes = pass_cnt;

  // Saturating count of vectors that ran out of passes with carries left
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_limit_hits <= '0;
    end else if (state == PASS && any_car && last_pass && !post_clean &&
                 stat_limit_hits != 16'hFFFF) begin
      stat_limit_hits <= stat_limit_hits + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_modulus_carry_normalizer.sv
// Directed self-checking bench for modulus_carry_normalizer (main instance plus a
// short-pass-limit instance that can actually exhaust its passes).
module tb_modulus_carry_normalizer;

  localparam int unsigned NW  = 4;
  localparam int unsigned BL  = 58;
  localparam int unsigned WL  = 51;
  localparam int unsigned MP  = 4;
  localparam int unsigned MP2 = 2;
  localparam int unsigned OL  = 16;

  typedef logic [NW-1:0][BL-1:0] sums_t;
  typedef logic [NW-1:0][WL-1:0] words_t;

  localparam logic [BL-1:0] P51 = BL'(1) << 51;
  localparam logic [BL-1:0] M51 = P51 - BL'(1);
  localparam logic [BL-1:0] P52 = BL'(1) << 52;

  logic   clk = 1'b0;
  logic   reset;
  logic   in_valid, in_valid2;
  logic   in_ready, in_ready2;
  sums_t  in_sums;
  logic   out_valid, out_valid2;
  logic   out_ready, out_ready2;
  words_t out_words, out_words2;
  logic [OL-1:0] out_ovf, out_ovf2;
  logic   out_clean, out_clean2;
`ifdef MODULUS_NORMALIZER_PASS_STATS_EN
  logic [$clog2(MP+1)-1:0]  out_passes;
  logic [$clog2(MP2+1)-1:0] out_passes2;
  logic [15:0]              stat_limit_hits, stat_limit_hits2;
`endif

  int errors = 0;
  int checks = 0;
  int lat;

  always #5 clk = ~clk;

  modulus_carry_normalizer #(
    .NUM_WORDS(NW), .BIT_LEN(BL), .WORD_LEN(WL), .MAX_PASSES(MP), .OVF_LEN(OL)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_sums(in_sums),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_words(out_words), .out_ovf(out_ovf), .out_clean(out_clean)
`ifdef MODULUS_NORMALIZER_PASS_STATS_EN
    , .out_passes(out_passes), .stat_limit_hits(stat_limit_hits)
`endif
  );

  modulus_carry_normalizer #(
    .NUM_WORDS(NW), .BIT_LEN(BL), .WORD_LEN(WL), .MAX_PASSES(MP2), .OVF_LEN(OL)
  ) dut2 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid2), .in_ready(in_ready2), .in_sums(in_sums),
    .out_valid(out_valid2), .out_ready(out_ready2),
    .out_words(out_words2), .out_ovf(out_ovf2), .out_clean(out_clean2)
`ifdef MODULUS_NORMALIZER_PASS_STATS_EN
    , .out_passes(out_passes2), .stat_limit_hits(stat_limit_hits2)
`endif
  );

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic sums_t mk_s(input logic [BL-1:0] a, b, c, d);
    sums_t s;
    s[0] = a; s[1] = b; s[2] = c; s[3] = d;
    return s;
  endfunction

  function automatic words_t mk_w(input logic [WL-1:0] a, b, c, d);
    words_t x;
    x[0] = a; x[1] = b; x[2] = c; x[3] = d;
    return x;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one vector to the main instance and wait (bounded) for its result
  task automatic send(input sums_t s, output int cyc);
    in_sums  = s;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      tick();
      cyc++;
    end
    if (!out_valid) check("timeout", 256'd0, 256'd1);
  endtask

  task automatic consume();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("consume_valid", out_valid, 1'b0);
    check("consume_ready", in_ready, 1'b1);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_valid2 = 1'b0;
    out_ready = 1'b0; out_ready2 = 1'b0; in_sums = '0;
    tick(); tick();
    reset = 1'b0;

    // Reset state and idle
    check("rst_words", out_words, '0);
    check("rst_clean", out_clean, 1'b0);
    for (int i = 0; i < 10; i++) begin
      check("idle_ready", in_ready, 1'b1);
      check("idle_valid", out_valid, 1'b0);
      check("idle_ovf", out_ovf, '0);
      tick();
    end

    // Already normalized vector: result in the second cycle after the accept edge
    send(mk_s(5, 6, 7, 8), lat);
    check("t2_lat", lat, 1);
    check("t2_words", out_words, mk_w(5, 6, 7, 8));
    check("t2_ovf", out_ovf, 0);
    check("t2_clean", out_clean, 1'b1);
`ifdef MODULUS_NORMALIZER_PASS_STATS_EN
    check("t2_passes", out_passes, 0);
`endif
    consume();

    // Single carry from word 0 into word 1
    send(mk_s(P51 + 3, 0, 0, 0), lat);
    check("t3_lat", lat, 2);
    check("t3_words", out_words, mk_w(3, 1, 0, 0));
    check("t3_clean", out_clean, 1'b1);
`ifdef MODULUS_NORMALIZER_PASS_STATS_EN
    check("t3_passes", out_passes, 1);
`endif
    consume();

    // Top-word carry goes to ovf; word 3 keeps only its low bits (zero)
    send(mk_s(M51, M51, M51, P52), lat);
    check("t4_words", out_words, mk_w(WL'(M51), WL'(M51), WL'(M51), 0));
    check("t4_ovf", out_ovf, 2);
    check("t4_clean", out_clean, 1'b1);
`ifdef MODULUS_NORMALIZER_PASS_STATS_EN
    check("t4_passes", out_passes, 1);
`endif
    consume();

    // Full ripple across all words, ending on the pass limit but clean
    send(mk_s(P52, M51, M51, M51), lat);
    check("t5_lat", lat, 4);
    check("t5_words", out_words, mk_w(0, 1, 0, 0));
    check("t5_ovf", out_ovf, 1);
    check("t5_clean", out_clean, 1'b1);
`ifdef MODULUS_NORMALIZER_PASS_STATS_EN
    check("t5_passes", out_passes, 4);
    check("t5_stat", stat_limit_hits, 0);
`endif

    // Backpressure: result held, competing vector ignored
    in_sums  = mk_s(9, 9, 9, 9);
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("bp_valid", out_valid, 1'b1);
      check("bp_ready", in_ready, 1'b0);
      check("bp_words", out_words, mk_w(0, 1, 0, 0));
      check("bp_ovf", out_ovf, 1);
      check("bp_clean", out_clean, 1'b1);
    end
    in_valid = 1'b0;
    consume();
    for (int i = 0; i < 4; i++) begin
      tick();
      check("bp_noaccept", out_valid, 1'b0);
      check("bp_idle", in_ready, 1'b1);
    end

    // Reset in the middle of a multi-pass vector discards it
    in_sums  = mk_s(P52, M51, M51, M51);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    check("mid_busy", in_ready, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_ready", in_ready, 1'b1);
    check("mid_valid", out_valid, 1'b0);
    check("mid_words", out_words, '0);
    check("mid_ovf", out_ovf, 0);
    for (int i = 0; i < 8; i++) begin
      tick();
      check("mid_novalid", out_valid, 1'b0);
    end

    // Reset and in_valid together: the vector is dropped
    in_sums = mk_s(P51 + 3, 0, 0, 0);
    reset = 1'b1; in_valid = 1'b1;
    tick();
    reset = 1'b0; in_valid = 1'b0;
    check("rv_ready", in_ready, 1'b1);
    tick();
    check("rv_valid", out_valid, 1'b0);
    check("rv_words", out_words, '0);

    // Two-pass instance: ripple chain runs out of passes
    in_sums   = mk_s(P52, M51, M51, M51);
    in_valid2 = 1'b1;
    tick();
    in_valid2 = 1'b0;
    lat = 0;
    while (!out_valid2 && lat < 20) begin
      tick();
      lat++;
    end
    if (!out_valid2) check("timeout2", 256'd0, 256'd1);
    check("lim_lat", lat, 2);
    check("lim_words", out_words2, mk_w(0, 1, 0, WL'(M51)));
    check("lim_ovf", out_ovf2, 0);
    check("lim_clean", out_clean2, 1'b0);
`ifdef MODULUS_NORMALIZER_PASS_STATS_EN
    check("lim_passes", out_passes2, 2);
    check("lim_stat", stat_limit_hits2, 1);
`endif
    out_ready2 = 1'b1;
    tick();
    out_ready2 = 1'b0;
    check("lim_consume", out_valid2, 1'b0);
    check("lim_idle", in_ready2, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
